// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR result display: FSM states, digit-select
// encodings, anode patterns and the active-low 7-segment glyph table.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SEL_ONES = 2'd0,
    SEL_TENS = 2'd1,
    SEL_HUND = 2'd2
  } sel_e;

  localparam logic [3:0] AN_ONES = 4'b1110;
  localparam logic [3:0] AN_TENS = 4'b1101;
  localparam logic [3:0] AN_HUND = 4'b1011;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam int unsigned BCD_ITERS = 8;

  // Segment order {g,f,e,d,c,b,a}, active-low; only 0..9 are ever selected.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] hex_seg(input logic [3:0] d);
    return SEG_TABLE[d];
  endfunction

  function automatic sel_e next_sel(input sel_e s);
    case (s)
      SEL_ONES: return SEL_TENS;
      SEL_TENS: return SEL_HUND;
      default:  return SEL_ONES;
    endcase
  endfunction

  function automatic logic [3:0] sel_anode(input sel_e s);
    case (s)
      SEL_ONES: return AN_ONES;
      SEL_TENS: return AN_TENS;
      default:  return AN_HUND;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit double-dabble converter: one add-3/shift iteration per clock,
// eight iterations after each load. A new load restarts the conversion.
module bin2bcd_seq
  import lfsr_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        done
);

  logic [19:0] sr_q, sr_d;
  logic [19:0] adj;
  logic [3:0]  cnt_q, cnt_d;
  logic        active_q, active_d;

  always_comb begin
    // NOTE: every variable assigned here gets a default first so no path can infer a latch.
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    adj      = sr_q;
    for (int i = 0; i < 3; i++) begin
      if (adj[8 + 4*i +: 4] >= 4'd5) adj[8 + 4*i +: 4] = adj[8 + 4*i +: 4] + 4'd3;
    end
    if (load) begin
      sr_d     = {12'b0, bin};
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      sr_d  = {adj[18:0], 1'b0};
      cnt_d = cnt_q + 4'd1;
      if (cnt_q == 4'(BCD_ITERS - 1)) active_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

  // High during the cycle whose closing edge performs the last iteration.
  assign done = active_q && (cnt_q == 4'(BCD_ITERS - 1));
  assign bcd  = sr_q[19:8];

endmodule

// File: rtl/lfsr_display.sv
// Captures the generator result on busy falling, converts it to BCD and scans three
// blanked decimal digits onto a common-anode 7-segment display.
module lfsr_display
  import lfsr_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       busy,
  input  logic [7:0] num,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       conv_busy
);

  localparam logic [15:0] RC_LAST = 16'(REFRESH_DIV - 1);

  logic        busy_q, busy_d;
  logic        capture;
  state_e      state_q, state_d;
  logic        load, done;
  logic [11:0] bcd;
  logic [3:0]  dig_h_q, dig_h_d, dig_t_q, dig_t_d, dig_o_q, dig_o_d;
  logic [15:0] rc_q, rc_d;
  sel_e        sel_q, sel_d;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        blank_h, blank_t;

  bin2bcd_seq u_bcd (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .bin  (num),
    .bcd  (bcd),
    .done (done)
  );

  assign capture = busy_q & ~busy;

  // A capture in any state restarts conversion; digits only change on completion.
  always_comb begin
    busy_d  = busy;
    state_d = state_q;
    load    = 1'b0;
    dig_h_d = dig_h_q;
    dig_t_d = dig_t_q;
    dig_o_d = dig_o_q;
    if (capture) begin
      load    = 1'b1;
      state_d = ST_SHIFT;
    end else begin
      case (state_q)
        ST_SHIFT: if (done) state_d = ST_DONE;
        ST_DONE: begin
          dig_h_d = bcd[11:8];
          dig_t_d = bcd[7:4];
          dig_o_d = bcd[3:0];
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign blank_h = (dig_h_q == 4'd0);
  assign blank_t = blank_h && (dig_t_q == 4'd0);

  // Anode and segments move together only at the refresh step, so a new value
  // shows up at the next digit change without restarting the scan.
  always_comb begin
    rc_d  = rc_q + 16'd1;
    sel_d = sel_q;
    an_d  = an_q;
    seg_d = seg_q;
    if (rc_q == RC_LAST) begin
      rc_d  = '0;
      sel_d = next_sel(sel_q);
      an_d  = sel_anode(sel_d);
      case (sel_d)
        SEL_ONES: seg_d = hex_seg(dig_o_q);
        SEL_TENS: seg_d = blank_t ? SEG_BLANK : hex_seg(dig_t_q);
        default:  seg_d = blank_h ? SEG_BLANK : hex_seg(dig_h_q);
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      state_q <= ST_IDLE;
      dig_h_q <= '0;
      dig_t_q <= '0;
      dig_o_q <= '0;
      rc_q    <= '0;
      sel_q   <= SEL_ONES;
      an_q    <= AN_ONES;
      seg_q   <= SEG_TABLE[0];
    end else begin
      busy_q  <= busy_d;
      state_q <= state_d;
      dig_h_q <= dig_h_d;
      dig_t_q <= dig_t_d;
      dig_o_q <= dig_o_d;
      rc_q    <= rc_d;
      sel_q   <= sel_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = 1'b1;
  assign conv_busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lfsr_display.sv
// Self-checking bench for lfsr_display: table of conversions with hand-derived glyphs,
// scoreboard of expected displays, plus abort and mid-conversion reset sequences.
module tb_lfsr_display;

  localparam int DIV = 4;

  localparam logic [6:0] S0  = 7'b1000000;
  localparam logic [6:0] S1  = 7'b1111001;
  localparam logic [6:0] S2  = 7'b0100100;
  localparam logic [6:0] S3  = 7'b0110000;
  localparam logic [6:0] S5  = 7'b0010010;
  localparam logic [6:0] S7  = 7'b1111000;
  localparam logic [6:0] S8  = 7'b0000000;
  localparam logic [6:0] S9  = 7'b0010000;
  localparam logic [6:0] SBL = 7'h7F;

  typedef struct {
    logic [7:0] num;
    logic [6:0] seg_h;
    logic [6:0] seg_t;
    logic [6:0] seg_o;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic [7:0] num;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       conv_busy;

  int n_tests = 0;
  int n_fail  = 0;

  vec_t vecs[8];
  vec_t sb_q[$];

  lfsr_display #(.REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy),
    .num      (num),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .conv_busy(conv_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // busy high for one cycle then low: the capture edge E0 is the next posedge.
  task automatic start_conv(input logic [7:0] n);
    @(negedge clk);
    busy = 1'b1;
    num  = n;
    @(negedge clk);
    busy = 1'b0;
  endtask

  task automatic wait_conv(input string tag);
    int n;
    int guard;
    n = 0;
    guard = 0;
    @(negedge clk);
    while (conv_busy && guard < 40) begin
      n++;
      guard++;
      @(negedge clk);
    end
    check({tag, " conv_busy_cycles"}, n, 9);
  endtask

  // Wait for a fresh digit step, then watch one full scan of 3*DIV cycles.
  task automatic collect_display(input string tag);
    logic [3:0] prev;
    int         waited;
    logic [6:0] s_h, s_t, s_o;
    int         c_h, c_t, c_o, c_bad, c_dp;
    vec_t       e;
    s_h = 'x; s_t = 'x; s_o = 'x;
    c_h = 0; c_t = 0; c_o = 0; c_bad = 0; c_dp = 0;
    @(negedge clk);
    prev   = an;
    waited = 0;
    while (an == prev && waited < 3*DIV) begin
      @(negedge clk);
      waited++;
    end
    check({tag, " step_seen"}, 32'(waited < 3*DIV), 1);
    for (int i = 0; i < 3*DIV; i++) begin
      case (an)
        4'b1110: begin s_o = seg; c_o++; end
        4'b1101: begin s_t = seg; c_t++; end
        4'b1011: begin s_h = seg; c_h++; end
        default: c_bad++;
      endcase
      if (dp !== 1'b1) c_dp++;
      @(negedge clk);
    end
    check({tag, " ones_cycles"}, c_o, DIV);
    check({tag, " tens_cycles"}, c_t, DIV);
    check({tag, " hund_cycles"}, c_h, DIV);
    check({tag, " bad_anode"}, c_bad, 0);
    check({tag, " dp_low"}, c_dp, 0);
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", tag);
    end else begin
      e = sb_q.pop_front();
      check({tag, " seg_hund"}, s_h, e.seg_h);
      check({tag, " seg_tens"}, s_t, e.seg_t);
      check({tag, " seg_ones"}, s_o, e.seg_o);
    end
  endtask

  initial begin
    vec_t zero_v;
    vecs[0] = '{8'd255, S2,  S5,  S5};
    vecs[1] = '{8'd8,   SBL, SBL, S8};
    vecs[2] = '{8'd105, S1,  S0,  S5};
    vecs[3] = '{8'd0,   SBL, SBL, S0};
    vecs[4] = '{8'd37,  SBL, S3,  S7};
    vecs[5] = '{8'd100, S1,  S0,  S0};
    vecs[6] = '{8'd99,  SBL, S9,  S9};
    vecs[7] = '{8'd10,  SBL, S1,  S0};
    zero_v  = '{8'd0,   SBL, SBL, S0};

    busy  = 1'b0;
    num   = 8'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset an", an, 4'b1110);
    check("reset seg", seg, S0);
    check("reset dp", dp, 1'b1);
    check("reset conv_busy", conv_busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("post_reset conv_busy", conv_busy, 1'b0);

    sb_q.push_back(zero_v);
    collect_display("reset_scan");

    foreach (vecs[i]) begin
      sb_q.push_back(vecs[i]);
      start_conv(vecs[i].num);
      wait_conv($sformatf("num%0d", vecs[i].num));
      collect_display($sformatf("num%0d", vecs[i].num));
    end

    // Abort: 200 is superseded before it completes and must never be displayed.
    start_conv(8'd200);
    repeat (4) @(negedge clk);
    check("abort midconv busy", conv_busy, 1'b1);
    sb_q.push_back(vecs[4]);
    start_conv(8'd37);
    wait_conv("abort37");
    collect_display("abort37");

    // Show 255, then reset in the middle of converting 99.
    sb_q.push_back(vecs[0]);
    start_conv(8'd255);
    wait_conv("pre_rst255");
    collect_display("pre_rst255");
    start_conv(8'd99);
    repeat (3) @(negedge clk);
    check("midrst in_shift", conv_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst an", an, 4'b1110);
    check("midrst seg", seg, S0);
    check("midrst conv_busy", conv_busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.push_back(zero_v);
    collect_display("after_rst");

    check("scoreboard drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_display.md
# lfsr_display

Downstream display stage for the pseudo-random generator. It watches the generator's `busy`/`num` pair and captures `num` when a run completes. It converts the value to BCD with a sequential shift-add-3 (double-dabble) engine and time-multiplexes the result as three decimal digits onto a common-anode 7-segment display with leading-zero blanking.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit is lit; minimum 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `busy`  in  1  generator busy flag; a high-to-low transition marks `num` valid.
- `num`  in  8  generator result, unsigned 0..255.
- `an`  out  4  digit anodes, active-low; `an[3]` always 1.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low; constant 1.
- `conv_busy`  out  1  high while a conversion is in progress.

## Operation
- Edge detect:
  - `busy_q` is a registered copy of `busy`, reset 0.
  - Capture event = `busy_q & ~busy`, sampled at a rising edge.
- FSM states, IDLE / SHIFT / DONE; reset state IDLE.
  - IDLE: on capture event, load the shift register with {12'b0, num}, clear iteration count, go to SHIFT.
  - SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift the whole 20-bit register left by 1, and increment the count. After the 8th iteration, go to DONE.
  - DONE: copy the BCD nibbles to `dig_h`, `dig_t`, `dig_o`, then go to IDLE.
- Capture event in SHIFT or DONE aborts the current conversion and reloads with the new `num`, returning to SHIFT with count 0. Digit registers keep their old values until a conversion completes.
- `conv_busy` is 1 in SHIFT and DONE, 0 in IDLE.
- Width rules:
  - Shift register is 20 bits: [19:16] hundreds, [15:12] tens, [11:8] ones, [7:0] binary.
  - Hundreds nibble never exceeds 2.
- Refresh:
  - 16-bit counter `rc` runs 0..REFRESH_DIV-1, then wraps.
  - At the terminal count, `sel` advances 0→1→2→0.
  - `sel` = 0 is ones (`an` = 1110), 1 is tens (1101), 2 is hundreds (1011).
- Blanking:
  - Hundreds is blank when `dig_h` = 0.
  - Tens is blank when `dig_h` = 0 and `dig_t` = 0.
  - Ones is never blank.
  - A blank digit drives `seg` = 7'h7F with its anode still asserted.
- `seg` is registered: decoded from the selected digit and updated on the same edge as `an`.

## Timing
- Reset values:
  - `an` = 4'b1110, `seg` = 7'b1000000 (shows "0"), `dp` = 1, `conv_busy` = 0.
  - `dig_*` = 0, `rc` = 0, `sel` = 0, `busy_q` = 0.
- Latency: capture at edge E0; iterations at E1..E8; digit registers valid after E9. `conv_busy` is high from after E0 through E9.
- A capture event on the first cycle out of reset is impossible, because `busy_q` resets to 0.
- Reset mid-conversion returns everything to reset values immediately, without waiting for a clock.
- Each digit is lit for exactly REFRESH_DIV cycles. New digit values appear at the next `sel` step, and the scan is not restarted.

## Structure
- Shared package `lfsr_pkg`:
  - FSM state enum.
  - Digit-select constants: anode patterns 1110/1101/1011.
  - `SEG_BLANK` = 7'h7F.
  - 16-entry hex-to-segment constant table, 0..9 used.
- One sub-module, `bin2bcd_seq`: 8-bit sequential double-dabble, with ports `clk`, `rst_n`, `load`, `bin[7:0]`, `bcd[11:0]`, `done`. The FSM drives `load` and consumes `done`.
- Refresh counter, blanking and segment decode stay in the top level.

## Test plan
- Reset → `an` = 1110, `seg` = 1000000, `conv_busy` = 0; with REFRESH_DIV = 4, `an` cycles 1110→1101→1011 every 4 cycles, and tens/hundreds show 7F.
- `num` = 255, `busy` pulse 1→0 → `conv_busy` high for 9 cycles; digits read 2, 5, 5 (`seg` 0100100, 0010010, 0010010).
- `num` = 8 → hundreds and tens blank, ones = 8 (`seg` 0000000).
- `num` = 105 → 1, 0, 5; the tens "0" is shown, not blank.
- Second falling edge 4 cycles into a conversion (`num` 200 then 37) → final digits blank, 3, 7; 200 is never displayed.
- `rst_n` low mid-SHIFT → outputs return to reset values asynchronously; previously displayed digits are cleared to "  0".
